// File: rtl/instr_fmt_pkg.sv
// Instruction word format shared by the field decoder and the word loader.
// Field positions are defined here once; pack_instr builds a 32-bit word
// from its decoded fields.
//   DATA [31:16]  OPC [15:12]  LI [11]  RW [10]  A1 [9:5]  A2 [4:0]
package instr_fmt_pkg;

    localparam int unsigned INSTR_W  = 32;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned DATA_LSB = 16;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned LI_W     = 1;
    localparam int unsigned LI_LSB   = 11;
    localparam int unsigned RW_W     = 1;
    localparam int unsigned RW_LSB   = 10;
    localparam int unsigned A1_W     = 5;
    localparam int unsigned A1_LSB   = 5;
    localparam int unsigned A2_W     = 5;
    localparam int unsigned A2_LSB   = 0;

    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [DATA_W-1:0] data,
        input logic [OPC_W-1:0]  opcode,
        input logic [LI_W-1:0]   load_imm,
        input logic [RW_W-1:0]   rw,
        input logic [A1_W-1:0]   addr1,
        input logic [A2_W-1:0]   addr2
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        w[DATA_LSB +: DATA_W] = data;
        w[OPC_LSB  +: OPC_W]  = opcode;
        w[LI_LSB   +: LI_W]   = load_imm;
        w[RW_LSB   +: RW_W]   = rw;
        w[A1_LSB   +: A1_W]   = addr1;
        w[A2_LSB   +: A2_W]   = addr2;
        return w;
    endfunction

endpackage

// File: rtl/instr_sync_fifo.sv
// Synchronous FIFO with registered storage and full/empty flags.
// Ports:
//   clk, rst_n     clock, async active-low reset (storage cleared)
//   push, wdata    write request/data (ignored when full)
//   pop            read request (ignored when empty)
//   rdata          head-of-queue word
//   full, empty    occupancy flags
module instr_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_word_loader.sv
// Instruction word loader: packs decoded field tuples into 32-bit words and
// writes them to instruction memory at consecutive addresses, one load of
// prog_len words per start command.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, base_addr, prog_len load command (sampled in IDLE)
//   in_valid/in_ready, in_*    field tuple handshake
//   mem_we/mem_ready           memory write handshake, mem_addr/mem_wdata
//   busy, done, wr_count       status
module instr_word_loader
    import instr_fmt_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     prog_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         in_data,
    input  logic [3:0]          in_opcode,
    input  logic                in_load_imm,
    input  logic                in_rw,
    input  logic [4:0]          in_addr1,
    input  logic [4:0]          in_addr2,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic                mem_ready,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     wr_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     acc_q;
    logic [ADDR_W:0]     wr_q;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [INSTR_W-1:0]  fifo_head;
    logic                last_write;
    logic                load_start;

    assign fifo_push  = in_valid && in_ready;
    assign fifo_pop   = mem_we && mem_ready;
    assign last_write = fifo_pop && ((wr_q + (ADDR_W+1)'(1)) == len_q);
    assign load_start = (state == S_IDLE) && start && (prog_len != '0);

    instr_sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (pack_instr(in_data, in_opcode, in_load_imm, in_rw, in_addr1, in_addr2)),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (prog_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                in_ready = !fifo_full && (acc_q < len_q);
                mem_we   = !fifo_empty;
                if (last_write) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            acc_q  <= '0;
            wr_q   <= '0;
        end else if (load_start) begin
            base_q <= base_addr;
            len_q  <= prog_len;
            acc_q  <= '0;
            wr_q   <= '0;
        end else begin
            if (fifo_push) acc_q <= acc_q + 1'b1;
            if (fifo_pop)  wr_q  <= wr_q + 1'b1;
        end
    end

    // Address and data only change on a completed write, so they stay put
    // while a write is stalled; zeroed when no write is requested.
    assign mem_addr  = mem_we ? (base_q + wr_q[ADDR_W-1:0]) : '0;
    assign mem_wdata = mem_we ? fifo_head : '0;
    assign wr_count  = wr_q;

endmodule

// File: tb/tb_instr_word_loader.sv
// Self-checking bench for instr_word_loader: randomized tuples and memory
// back-pressure checked against a queue-based reference model.
module tb_instr_word_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   prog_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_data = '0;
    logic [3:0]        in_opcode = '0;
    logic              in_load_imm = 1'b0;
    logic              in_rw = 1'b0;
    logic [4:0]        in_addr1 = '0;
    logic [4:0]        in_addr2 = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready = 1'b0;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;

    int compared   = 0;
    int mismatched = 0;

    instr_word_loader #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .prog_len    (prog_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_opcode   (in_opcode),
        .in_load_imm (in_load_imm),
        .in_rw       (in_rw),
        .in_addr1    (in_addr1),
        .in_addr2    (in_addr2),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .done        (done),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference packing from the word layout, plain arithmetic.
    function automatic logic [31:0] ref_word(int unsigned d, int unsigned o, int unsigned li,
                                             int unsigned rw, int unsigned a1, int unsigned a2);
        int unsigned w;
        w = d * 65536 + o * 4096 + li * 2048 + rw * 1024 + a1 * 32 + a2;
        return w;
    endfunction

    task automatic randomize_tuple(input bit fixed);
        if (fixed) begin
            in_data = 16'hABCD; in_opcode = 4'd3; in_load_imm = 1'b1;
            in_rw = 1'b0; in_addr1 = 5'd5; in_addr2 = 5'd9;
        end else begin
            in_data = 16'($urandom); in_opcode = 4'($urandom); in_load_imm = 1'($urandom);
            in_rw = 1'($urandom); in_addr1 = 5'($urandom); in_addr2 = 5'($urandom);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wr_count"}, wr_count, 0);
    endtask

    // One full load. Model: occupancy = accepted - written; words leave in
    // acceptance order to base+k mod 2^ADDR_W.
    task automatic do_load(input int unsigned base, input int unsigned len, input int unsigned rdy_pct,
                           input int unsigned val_pct, input int unsigned hold, input bit fixed,
                           input bit poke_start);
        int unsigned acc, wr, cyc;
        int last_wr;
        bit running, prev_stall, exp_rdy;
        logic [ADDR_W-1:0] prev_addr;
        logic [31:0] prev_data, exp_w;
        logic [31:0] q[$];

        @(negedge clk);
        in_valid = 1'b1; mem_ready = 1'b1;
        start = 1'b1; base_addr = ADDR_W'(base); prog_len = (ADDR_W+1)'(len);
        #1;
        chk("idle_in_ready", in_ready, 0);
        chk("idle_mem_we", mem_we, 0);
        @(negedge clk);
        start = 1'b0; base_addr = ADDR_W'($urandom); prog_len = (ADDR_W+1)'($urandom);

        acc = 0; wr = 0; cyc = 0; last_wr = -1; running = 1'b1; prev_stall = 1'b0;
        prev_addr = '0; prev_data = '0;
        while (running && cyc < 3000) begin
            in_valid = ($urandom_range(99) < val_pct);
            randomize_tuple(fixed);
            mem_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (poke_start && cyc == 2) begin
                start = 1'b1; base_addr = ADDR_W'($urandom); prog_len = (ADDR_W+1)'($urandom_range(1, 200));
            end else begin
                start = 1'b0;
            end
            #1;
            exp_rdy = ((acc - wr) < DEPTH) && (acc < len);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_in_ready", in_ready, exp_rdy);
            chk("run_mem_we", mem_we, acc > wr);
            chk("run_wr_count", wr_count, wr);
            if (prev_stall) begin
                chk("stall_addr", mem_addr, prev_addr);
                chk("stall_data", mem_wdata, prev_data);
            end
            if (hold > 0 && cyc == hold - 1)
                chk("hold_accepts", acc, (len < DEPTH) ? len : DEPTH);
            if (mem_we && mem_ready) begin
                chk("write_has_word", q.size() > 0, 1);
                exp_w = (q.size() > 0) ? q.pop_front() : 32'hx;
                chk("write_data", mem_wdata, exp_w);
                chk("write_addr", mem_addr, (base + wr) % (1 << ADDR_W));
                if (fixed) chk("write_fixed_word", mem_wdata, 32'hABCD38A9);
                wr++;
                last_wr = int'(cyc);
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_word(in_data, in_opcode, in_load_imm, in_rw, in_addr1, in_addr2));
                acc++;
            end
            prev_stall = mem_we && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
            if (wr == len) running = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("load_timeout", running, 0);
        start = 1'b0; in_valid = 1'b1; mem_ready = 1'b1;
        #1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_mem_we", mem_we, 0);
        chk("done_in_ready", in_ready, 0);
        chk("done_wr_count", wr_count, len);
        chk("done_accepts", acc, len);
        if (rdy_pct == 100 && val_pct == 100 && hold == 0)
            chk("full_rate_last_write", last_wr, len);
        @(negedge clk);
        #1;
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        chk("after_in_ready", in_ready, 0);
        chk("after_mem_we", mem_we, 0);
        chk("after_wr_count", wr_count, len);
    endtask

    initial begin
        int unsigned rbase;

        // Reset with random inputs applied.
        start = 1'($urandom); base_addr = ADDR_W'($urandom); prog_len = (ADDR_W+1)'($urandom);
        in_valid = 1'b1; mem_ready = 1'b1; randomize_tuple(1'b0);
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Fixed tuple, full rate.
        do_load(32'h10, 3, 100, 100, 0, 1'b1, 1'b0);
        // Memory stalled: FIFO fills, then drains in order.
        do_load($urandom_range(255), 6, 100, 100, 10, 1'b0, 1'b0);
        // Address wrap.
        do_load(32'hFE, 4, 100, 100, 0, 1'b0, 1'b0);

        // Zero-length load.
        @(negedge clk);
        start = 1'b1; prog_len = '0; in_valid = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 1);
        chk("len0_mem_we", mem_we, 0);
        chk("len0_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        chk("len0_after_done", done, 0);
        chk("len0_after_busy", busy, 0);
        chk("len0_after_mem_we", mem_we, 0);

        // Start pulsed during RUN, random handshakes.
        do_load($urandom_range(255), 8, 60, 70, 0, 1'b0, 1'b1);

        // Reset after 2 of 5 writes.
        rbase = $urandom_range(255);
        @(negedge clk);
        start = 1'b1; base_addr = ADDR_W'(rbase); prog_len = 9'd5; in_valid = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_pre_wr_count", wr_count, 2);
        chk("abort_pre_mem_we", mem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("abort_hold_mem_we", mem_we, 0);
            chk("abort_hold_busy", busy, 0);
        end
        rst_n = 1'b1;
        do_load(rbase, 5, 100, 100, 0, 1'b0, 1'b0);

        // Random loads.
        for (int i = 0; i < 4; i++)
            do_load($urandom_range(255), $urandom_range(1, 24), $urandom_range(30, 100),
                    $urandom_range(30, 100), 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_word_loader.md
Name: instr_word_loader

Overview:
- Inverse of the instruction field decoder: accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit instruction words.
- Packed words pass through a small FIFO and are written to instruction memory at consecutive addresses.
- Used to load programs into the processor's instruction memory, from a host or testbench, before execution.
- Runs one load of a programmed length per start command.

Parameters:
- ADDR_W, 8, instruction memory address width; addresses wrap modulo 2^ADDR_W.
- FIFO_DEPTH, 4, packed-word buffer depth; power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a load; sampled only in IDLE
- base_addr  input  ADDR_W  first write address, latched on start
- prog_len  input  ADDR_W+1  number of words to load, latched on start
- in_valid  input  1  field tuple valid
- in_ready  output  1  tuple accepted when in_valid && in_ready
- in_data  input  16  immediate/data field
- in_opcode  input  4  opcode field
- in_load_imm  input  1  load-immediate flag
- in_rw  input  1  read/write flag
- in_addr1  input  5  first register address
- in_addr2  input  5  second register address
- mem_we  output  1  memory write request
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  32  packed instruction word
- mem_ready  input  1  write completes when mem_we && mem_ready
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse at end of load
- wr_count  output  ADDR_W+1  words written in the current/last load

Behaviour:
- Packing: word = {in_data, in_opcode, in_load_imm, in_rw, in_addr1, in_addr2}, occupying bits 31:16, 15:12, 11, 10, 9:5 and 4:0 respectively.
- Reset (async, rst_n=0): state IDLE; FIFO emptied and storage cleared; all counters and latched registers cleared.
- Outputs under reset: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, wr_count=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0, mem_we=0.
  - start && prog_len!=0: latch base_addr and prog_len, clear accepted and written counters and wr_count, go to RUN.
  - start && prog_len==0: go to DONE; no memory writes.
- RUN, input side:
  - in_ready = !fifo_full && (accepted < len).
  - Each handshake pushes the packed word and increments accepted.
- RUN, memory side:
  - mem_we = !fifo_empty; mem_wdata = FIFO head; mem_addr = (base + written) mod 2^ADDR_W.
  - mem_addr and mem_wdata are held stable while mem_we && !mem_ready.
  - On mem_we && mem_ready: pop, increment written and wr_count.
- RUN to DONE: in the cycle the write making written==len completes.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE.
- Latency: a word accepted in cycle N is presented on mem_we/mem_wdata no earlier than cycle N+1, because FIFO storage is registered. With mem_ready=1 and continuous in_valid, throughput is 1 word/cycle.
- Simultaneous push and pop on a non-empty FIFO: both occur and occupancy is unchanged. No push when full, since in_ready is low.
- Tuples offered beyond len are never accepted.
- Reset asserted mid-load aborts immediately. No further mem_we, and no partially written state is retained.

Decomposition:
- Shared package instr_fmt_pkg holds:
  - field width and LSB constants: DATA 16@16, OPC 4@12, LI 1@11, RW 1@10, A1 5@5, A2 5@0;
  - INSTR_W=32;
  - a pack_instr function.
  - The same package serves the decoder, so field positions are defined once.
- One sub-module: instr_sync_fifo, parameterised on width 32 and FIFO_DEPTH, with full/empty flags and async active-low reset.

Test Plan:
- Reset applied mid-idle with random inputs → all outputs 0, in_ready=0, busy=0.
- base=0x10, len=3, mem_ready=1, tuple data=0xABCD opc=3 li=1 rw=0 a1=5 a2=9 repeated → writes of 0xABCD38A9 at 0x10, 0x11, 0x12 on consecutive cycles, done one cycle after the last write, wr_count=3.
- len=6, mem_ready held 0 → exactly 4 accepts, then in_ready=0 with mem_we=1 and address/data stable. Release mem_ready → remaining 2 words accepted, all 6 written in input order.
- base=0xFE, len=4 → mem_addr sequence 0xFE, 0xFF, 0x00, 0x01.
- start with len=0 → done pulses the next cycle, mem_we never asserted. start pulsed during RUN is ignored.
- Reset asserted after 2 of 5 writes → outputs cleared asynchronously, no further mem_we. A new start afterwards runs a full clean load.
